// File: rtl/sel_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sel_mux_pkg
// Description : Shared types and constants for the pipelined channel selector.
// Revision    : 1.0
// ============================================================================
package sel_mux_pkg;

    // Upper bound on the select width that the sideband record can carry.
    localparam int MAX_SEL_W = 16;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef struct packed {
        logic                 valid;
        logic                 en_n;
        logic [MAX_SEL_W-1:0] sel;
    } side_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sel_mux_stage.sv
`default_nettype none
// ============================================================================
// Module      : sel_mux_stage
// Description : One registered 2:1 reduction level of the selector tree.
// Revision    : 1.0
// ============================================================================
module sel_mux_stage
    import sel_mux_pkg::*;
#(
    parameter int CAND    = 2,
    parameter int DATA_W  = 1,
    parameter int SEL_BIT = 0,
    parameter bit GATE_EN = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_hold,
    input  logic [CAND*DATA_W-1:0]       i_data,
    input  side_t                        i_side,
    output logic [(CAND/2)*DATA_W-1:0]   o_data,
    output side_t                        o_side
);

    localparam int HALF = CAND / 2;

    logic [HALF*DATA_W-1:0] r_data_q;
    logic [HALF*DATA_W-1:0] w_data_d;
    side_t                  r_side_q;
    side_t                  w_side_d;

    always_comb begin
        w_data_d = r_data_q;
        w_side_d = r_side_q;
        if (!i_hold) begin
            w_side_d = i_side;
            for (int k = 0; k < HALF; k++) begin
                w_data_d[k*DATA_W +: DATA_W] = i_side.sel[SEL_BIT]
                    ? i_data[(2*k+1)*DATA_W +: DATA_W]
                    : i_data[(2*k)*DATA_W +: DATA_W];
            end
            // Gating is applied once, at the final level, so dout is a clean register.
            if (GATE_EN && i_side.en_n) begin
                w_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
            r_side_q <= '0;
        end else begin
            r_data_q <= w_data_d;
            r_side_q <= w_side_d;
        end
    end

    assign o_data = r_data_q;
    assign o_side = r_side_q;

endmodule
`default_nettype wire

// File: rtl/sel_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sel_mux_pipe
// Description : Pipelined N:1 channel selector with handshake and auto-scan.
// Revision    : 1.0
// ============================================================================
module sel_mux_pipe
    import sel_mux_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int SEL_W  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [(1<<SEL_W)*DATA_W-1:0]    din,
    input  logic [SEL_W-1:0]                sel,
    input  logic                            mode,
    input  logic                            en_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               dout,
    output logic [DATA_W-1:0]               dout_n,
    output logic [SEL_W-1:0]                chan_out
);

    localparam int N = 1 << SEL_W;

    logic               w_stall;
    logic               w_accept;
    logic [SEL_W-1:0]   w_eff_sel;
    logic [SEL_W-1:0]   r_scan_cnt_q;
    logic [SEL_W-1:0]   w_scan_cnt_d;

    // Every tree level packed back to back: level with C candidates starts at (2N-2C)*DATA_W.
    logic [(2*N-1)*DATA_W-1:0] w_tree;
    side_t                     w_side [0:SEL_W];

    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_accept  = in_valid & in_ready;
    assign w_eff_sel = (mode == MODE_SCAN) ? r_scan_cnt_q : sel;

    always_comb begin
        w_scan_cnt_d = r_scan_cnt_q;
        if (w_accept && (mode == MODE_SCAN)) begin
            w_scan_cnt_d = r_scan_cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt_q <= '0;
        end else begin
            r_scan_cnt_q <= w_scan_cnt_d;
        end
    end

    always_comb begin
        w_side[0]       = '0;
        w_side[0].valid = w_accept;
        w_side[0].en_n  = en_n;
        w_side[0].sel   = MAX_SEL_W'(w_eff_sel);
    end

    assign w_tree[N*DATA_W-1:0] = din;

    generate
        for (genvar j = 0; j < SEL_W; j++) begin : g_stage
            localparam int CAND    = N >> j;
            localparam int IN_OFF  = (2*N - 2*CAND) * DATA_W;
            localparam int OUT_OFF = (2*N - CAND) * DATA_W;

            sel_mux_stage #(
                .CAND    (CAND),
                .DATA_W  (DATA_W),
                .SEL_BIT (j),
                .GATE_EN (j == SEL_W - 1)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .i_hold (w_stall),
                .i_data (w_tree[IN_OFF +: CAND*DATA_W]),
                .i_side (w_side[j]),
                .o_data (w_tree[OUT_OFF +: (CAND/2)*DATA_W]),
                .o_side (w_side[j+1])
            );
        end

        // The final record's en_n and padding bits have no consumer past the output stage.
        if (SEL_W < MAX_SEL_W) begin : g_sel_pad
            logic w_unused_side;
            assign w_unused_side = ^{w_side[SEL_W].en_n, w_side[SEL_W].sel[MAX_SEL_W-1:SEL_W]};
        end else begin : g_sel_full
            logic w_unused_side;
            assign w_unused_side = w_side[SEL_W].en_n;
        end
    endgenerate

    assign out_valid = w_side[SEL_W].valid;
    assign chan_out  = w_side[SEL_W].sel[SEL_W-1:0];
    assign dout      = w_tree[(2*N-2)*DATA_W +: DATA_W];
    assign dout_n    = ~dout;

endmodule
`default_nettype wire

// File: doc/sel_mux_pipe.md
# sel_mux_pipe

Parametrised, pipelined N:1 channel selector with active-low enable gating and a true/complement output pair. It generalises the combinational 8:1 single-bit selector to configurable data width and channel count. It adds one register per 2:1 tree level, a valid/ready handshake with backpressure, and an auto-scan mode in which an internal counter sweeps the channels. It sits between a bank of parallel sources and a single-lane consumer.

## Interface
- `DATA_W`, default 1: bits per channel.
- `SEL_W`, default 3: select width. Channel count is N = 2^SEL_W. `SEL_W` ≥ 1.
- `clk`, in, 1: the only clock. All state updates on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `din`, in, N*DATA_W: flat channel bus. Channel k occupies `din[k*DATA_W +: DATA_W]`.
- `sel`, in, SEL_W: channel index used in direct mode.
- `mode`, in, 1: 0 = direct (use `sel`), 1 = scan (use the internal counter).
- `en_n`, in, 1: active-low enable. When 1, the beat's data is forced to all-zero.
- `in_valid`, in, 1: the input beat is present.
- `in_ready`, out, 1: the pipe can accept a beat this cycle.
- `out_valid`, out, 1: `dout` holds a beat.
- `out_ready`, in, 1: the consumer takes the beat this cycle.
- `dout`, out, DATA_W: selected data.
- `dout_n`, out, DATA_W: bitwise complement of `dout` at all times.
- `chan_out`, out, SEL_W: channel index that produced `dout`.

## Operation
- **Accept.** A beat is accepted when `in_valid & in_ready`. On acceptance, these are captured into stage 0:
  - the effective select, `eff_sel` = `mode ? scan_cnt : sel`;
  - `en_n`;
  - `din`.
- **Tree.** Stage j (j = 0..SEL_W-1) reduces 2^(SEL_W-j) candidates to half, using bit j of `eff_sel`.
  - Bit 0 is the LSB and is resolved first.
  - `eff_sel`, `en_n` and `valid` travel with the data.
- **Output.** The last stage's register drives `dout`, `chan_out` and `out_valid`. `dout` = `en_n ? 0 : din[eff_sel]` of the accepted beat.
- **Scan counter.**
  - `scan_cnt` is SEL_W bits and resets to 0.
  - It increments by 1 on each accepted beat while `mode`=1, and wraps from N-1 to 0.
  - It holds while `mode`=0 and resumes from its held value when `mode` returns to 1.
- **Stall.** `stall` = `out_valid & ~out_ready`. While `stall`=1:
  - every stage holds;
  - `in_ready`=0;
  - `scan_cnt` holds.
  
  Otherwise every stage advances, and bubbles (valid=0) propagate normally. `in_ready` = `~stall`, a combinational function of output state only (no dependency on `in_valid`).
- **Reset.** Takes effect on the clock edge while `rst`=1. It clears:
  - all stage valids, so `out_valid`=0;
  - `dout` to 0, so `dout_n` = all-ones;
  - `chan_out` to 0;
  - `scan_cnt` to 0.
  
  In-flight beats are discarded. `rst` overrides acceptance in the same cycle.
- **Simultaneous events.** A mode change in the same cycle as acceptance takes effect for that beat. `eff_sel` uses the current `mode` and the pre-increment `scan_cnt`.

## Timing
- **Latency.** Exactly SEL_W cycles from acceptance to `out_valid` with no stalls. Beat accepted at edge t appears after edge t+SEL_W-1 and is visible in cycle t+SEL_W. For SEL_W=3: accept in cycle 0, `out_valid` in cycle 3.
- **Throughput.** One beat per cycle while `out_ready`=1.
- **Stalls.** Each stall cycle adds one cycle of latency to every in-flight beat. No beat is lost or duplicated.
- **Combinational paths.** `dout_n` is combinational from the `dout` register. No combinational path from `din` to `dout`.

## Structure
- **Shared package `sel_mux_pkg`:**
  - function `clog2`;
  - a typedef for the per-stage sideband record `{valid, en_n, sel}`;
  - the mode encodings `MODE_DIRECT=0` and `MODE_SCAN=1`.
- **Sub-module `sel_mux_stage`:** one registered 2:1 reduction level, parameterised by candidate count and `DATA_W`, with a hold input. The top generates SEL_W instances and owns `scan_cnt` and the stall logic.

## Test plan
- **Direct select.** DATA_W=4, SEL_W=3, `din` channel k = k+1, `sel`=5, `en_n`=0, `out_ready`=1, single beat → in cycle 3: `dout`=6, `dout_n`=4'h9, `chan_out`=5, `out_valid`=1 for one cycle.
- **Enable gating.** Same stimulus with `en_n`=1 → `dout`=0, `dout_n`=4'hF, `chan_out`=5, `out_valid`=1.
- **Scan wrap.** `mode`=1, 10 back-to-back beats → `chan_out` sequence 0,1,…,7,0,1 starting cycle 3. `dout` matches the channel values.
- **Backpressure.** Stream 6 beats, hold `out_ready`=0 for 4 cycles mid-stream → `in_ready`=0 during the stall. All 6 beats are delivered in order, with no duplicates. `scan_cnt` is frozen during the stall.
- **Mode toggle.** Scan 3 beats, then direct with `sel`=6 for 2 beats, then scan 1 beat → `chan_out` = 0,1,2,6,6,3.
- **Reset mid-operation.** Assert `rst` for one cycle with 3 beats in flight → the next cycle shows `out_valid`=0, `dout`=0, `dout_n`=all-ones. No stale beat emerges. Scan restarts at channel 0.
